// File: rtl/pong_pkg.sv
// Shared constants and types for the pong display path: screen and court geometry,
// RGB565 colours and the renderer state encoding.
package pong_pkg;

    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 320;

    localparam int COURT_LEFT   = 0;
    localparam int COURT_RIGHT  = SCREEN_W - 1;
    localparam int COURT_TOP    = 0;
    localparam int COURT_BOTTOM = SCREEN_H - 1;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ERASE,
        DRAW,
        FINISH
    } render_state_t;

    // Pixel addresses are formed in 10 bits so a sprite hanging off the edge never wraps.
    function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y,
                                       input int width, input int height);
        return (x < 10'(width)) && (y < 10'(height));
    endfunction

endpackage

// File: rtl/sprite_raster.sv
// Rasters a SIZE x SIZE square from a latched base, skipping off-screen pixels and
// presenting each visible pixel on a held valid/ready write port.
module sprite_raster
    import pong_pkg::*;
#(
    parameter int SIZE     = 10,
    parameter int SCREEN_W = pong_pkg::SCREEN_W,
    parameter int SCREEN_H = pong_pkg::SCREEN_H
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  base_x,
    input  logic [8:0]  base_y,
    input  logic [15:0] colour,
    input  logic        pixel_ready,
    output logic [7:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_colour,
    output logic        pixel_write,
    output logic        last
);

    localparam int            CW         = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_INDEX = CW'(SIZE - 1);

    logic          active;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [CW-1:0] next_cx;
    logic [CW-1:0] next_cy;
    logic [CW-1:0] load_cx;
    logic [CW-1:0] load_cy;
    logic [7:0]    held_x;
    logic [8:0]    held_y;
    logic [15:0]   held_colour;
    logic [7:0]    load_base_x;
    logic [8:0]    load_base_y;
    logic [15:0]   load_colour;
    logic [9:0]    addr_x;
    logic [9:0]    addr_y;
    logic          visible;
    logic          at_end;
    logic          advance;

    assign at_end  = (cx == LAST_INDEX) && (cy == LAST_INDEX);
    assign advance = active && (!pixel_write || pixel_ready);
    assign last    = advance && at_end;

    always_comb begin
        next_cx = cx + 1'b1;
        next_cy = cy;
        if (cx == LAST_INDEX) begin
            next_cx = '0;
            next_cy = cy + 1'b1;
        end
    end

    // A start presents pixel (0,0) of the new square; otherwise the next raster position.
    always_comb begin
        load_base_x = held_x;
        load_base_y = held_y;
        load_colour = held_colour;
        load_cx     = next_cx;
        load_cy     = next_cy;
        if (start) begin
            load_base_x = base_x;
            load_base_y = base_y;
            load_colour = colour;
            load_cx     = '0;
            load_cy     = '0;
        end
        addr_x  = {2'b00, load_base_x} + 10'(load_cx);
        addr_y  = {1'b0, load_base_y} + 10'(load_cy);
        visible = on_screen(addr_x, addr_y, SCREEN_W, SCREEN_H);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active       <= 1'b0;
            cx           <= '0;
            cy           <= '0;
            held_x       <= '0;
            held_y       <= '0;
            held_colour  <= '0;
            pixel_write  <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            pixel_colour <= '0;
        end else if (start) begin
            active       <= 1'b1;
            cx           <= '0;
            cy           <= '0;
            held_x       <= base_x;
            held_y       <= base_y;
            held_colour  <= colour;
            pixel_write  <= visible;
            pixel_x      <= addr_x[7:0];
            pixel_y      <= addr_y[8:0];
            pixel_colour <= load_colour;
        end else if (advance) begin
            if (at_end) begin
                active      <= 1'b0;
                pixel_write <= 1'b0;
                cx          <= '0;
                cy          <= '0;
            end else begin
                cx           <= next_cx;
                cy           <= next_cy;
                pixel_write  <= visible;
                pixel_x      <= addr_x[7:0];
                pixel_y      <= addr_y[8:0];
                pixel_colour <= load_colour;
            end
        end
    end

endmodule

// File: rtl/ball_renderer.sv
// Repaints the ball sprite on each update: erases the previously drawn square in the
// background colour, then draws the square at the newly sampled position.
module ball_renderer
    import pong_pkg::*;
#(
    parameter int          SIZE        = 10,
    parameter int          SCREEN_W    = pong_pkg::SCREEN_W,
    parameter int          SCREEN_H    = pong_pkg::SCREEN_H,
    parameter logic [15:0] BALL_COLOUR = RGB565_WHITE,
    parameter logic [15:0] BG_COLOUR   = RGB565_BLACK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ball_x,
    input  logic [8:0]  ball_y,
    input  logic        update,
    output logic [7:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_colour,
    output logic        pixel_write,
    input  logic        pixel_ready,
    output logic        busy,
    output logic        done
);

    render_state_t state;
    render_state_t next_state;

    logic [7:0]  new_x;
    logic [8:0]  new_y;
    logic [7:0]  old_x;
    logic [8:0]  old_y;
    logic        old_valid;
    logic        pending;
    logic        take_update;
    logic        same_position;
    logic        raster_start;
    logic        raster_last;
    logic [7:0]  raster_x;
    logic [8:0]  raster_y;
    logic [15:0] raster_colour;

    assign take_update   = (state == IDLE) && (update || pending);
    assign same_position = old_valid && (new_x == old_x) && (new_y == old_y);
    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);

    // The raster is started in the same cycle the FSM leaves LATCH or finishes ERASE,
    // so the first pixel of each square follows the previous one without a gap.
    always_comb begin
        next_state    = state;
        raster_start  = 1'b0;
        raster_x      = new_x;
        raster_y      = new_y;
        raster_colour = BALL_COLOUR;
        case (state)
            IDLE: begin
                if (update || pending) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                if (same_position) begin
                    next_state = FINISH;
                end else if (old_valid) begin
                    next_state    = ERASE;
                    raster_start  = 1'b1;
                    raster_x      = old_x;
                    raster_y      = old_y;
                    raster_colour = BG_COLOUR;
                end else begin
                    next_state   = DRAW;
                    raster_start = 1'b1;
                end
            end
            ERASE: begin
                if (raster_last) begin
                    next_state   = DRAW;
                    raster_start = 1'b1;
                end
            end
            DRAW: begin
                if (raster_last) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Updates arriving while busy collapse into one pending repaint; the position is
    // sampled only when IDLE consumes it, so the latest ball position wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            old_valid <= 1'b0;
            new_x     <= '0;
            new_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
        end else begin
            state <= next_state;
            if (take_update) begin
                new_x   <= ball_x;
                new_y   <= ball_y;
                pending <= 1'b0;
            end else if (update && (state != IDLE)) begin
                pending <= 1'b1;
            end
            if (state == FINISH) begin
                old_x     <= new_x;
                old_y     <= new_y;
                old_valid <= 1'b1;
            end
        end
    end

    sprite_raster #(
        .SIZE     (SIZE),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .start        (raster_start),
        .base_x       (raster_x),
        .base_y       (raster_y),
        .colour       (raster_colour),
        .pixel_ready  (pixel_ready),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_colour (pixel_colour),
        .pixel_write  (pixel_write),
        .last         (raster_last)
    );

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: directed repaints plus random ready and
// positions, scored against a square-painting reference model.
module tb_ball_renderer;

    localparam int SIZE     = 10;
    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 320;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ball_x;
    logic [8:0]  ball_y;
    logic        update;
    logic [7:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [15:0] pixel_colour;
    logic        pixel_write;
    logic        pixel_ready;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    ball_renderer dut (
        .clock        (clock),
        .reset        (reset),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .update       (update),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_colour (pixel_colour),
        .pixel_write  (pixel_write),
        .pixel_ready  (pixel_ready),
        .busy         (busy),
        .done         (done)
    );

    typedef logic [32:0] pix_t;

    int   compared   = 0;
    int   mismatched = 0;
    pix_t expq[$];
    pix_t gotq[$];

    bit   m_valid;
    int   m_x;
    int   m_y;

    bit   ready_random;
    bit   held;
    pix_t prev_pix;
    int   idx;
    int   xfers;
    int   last_xfer_idx;
    int   done_idx;
    int   done_count;
    int   busy_low;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_square(input int bx, input int by, input logic [15:0] col);
        for (int cy = 0; cy < SIZE; cy++) begin
            for (int cx = 0; cx < SIZE; cx++) begin
                int x;
                int y;
                x = bx + cx;
                y = by + cy;
                if (x < SCREEN_W && y < SCREEN_H) expq.push_back({8'(x), 9'(y), col});
            end
        end
    endtask

    task automatic model_repaint(input int nx, input int ny);
        if (!(m_valid && nx == m_x && ny == m_y)) begin
            if (m_valid) model_square(m_x, m_y, 16'h0000);
            model_square(nx, ny, 16'hFFFF);
        end
        m_valid = 1'b1;
        m_x     = nx;
        m_y     = ny;
    endtask

    // One clock: observe at the falling edge, drive new ready just after the rising edge.
    task automatic step();
        @(negedge clock);
        if (held)
            check_output("hold", 64'({pixel_write, pixel_x, pixel_y, pixel_colour}),
                         64'({1'b1, prev_pix}));
        if (pixel_write && pixel_ready) begin
            gotq.push_back({pixel_x, pixel_y, pixel_colour});
            xfers++;
            last_xfer_idx = idx;
        end
        if (done) begin
            done_count++;
            if (done_idx < 0) done_idx = idx;
        end
        if (!busy) busy_low++;
        held     = pixel_write && !pixel_ready;
        prev_pix = {pixel_x, pixel_y, pixel_colour};
        idx++;
        @(posedge clock);
        #1;
        pixel_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        update      = 1'b0;
        pixel_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_write", 64'(pixel_write), 64'(0));
        check_output("reset_x", 64'(pixel_x), 64'(0));
        check_output("reset_y", 64'(pixel_y), 64'(0));
        check_output("reset_colour", 64'(pixel_colour), 64'(0));
        check_output("reset_busy", 64'(busy), 64'(0));
        check_output("reset_done", 64'(done), 64'(0));
        reset   = 1'b0;
        m_valid = 1'b0;
        held    = 1'b0;
    endtask

    // Pulses update at (nx,ny); optionally re-pulses update at inject_at and moves the
    // ball ten cycles later, which should produce a second repaint at the later spot.
    task automatic run_repaint(input string tag, input int nx, input int ny, input bit rand_ready,
                               input int inject_at, input int later_x, input int later_y,
                               input int want_done_idx, input bit check_tail);
        int dones_wanted;
        dones_wanted = (inject_at >= 0) ? 2 : 1;
        expq.delete();
        gotq.delete();
        model_repaint(nx, ny);
        if (inject_at >= 0) model_repaint(later_x, later_y);
        ready_random = rand_ready;
        held   = 1'b0;
        ball_x = 8'(nx);
        ball_y = 9'(ny);
        update = 1'b1;
        step();
        update = 1'b0;
        idx = 0; xfers = 0; last_xfer_idx = -1; done_idx = -1; done_count = 0; busy_low = 0;
        gotq.delete();
        while (done_count < dones_wanted && idx < 3000) begin
            if (inject_at >= 0 && idx == inject_at) update = 1'b1;
            if (inject_at >= 0 && idx == inject_at + 10) begin
                ball_x = 8'(later_x);
                ball_y = 9'(later_y);
            end
            step();
            update = 1'b0;
        end
        ready_random = 1'b0;
        pixel_ready  = 1'b1;
        check_output({tag, "_dones"}, 64'(done_count), 64'(dones_wanted));
        check_output({tag, "_xfers"}, 64'(gotq.size()), 64'(expq.size()));
        for (int i = 0; i < gotq.size() && i < expq.size(); i++)
            check_output($sformatf("%s_pix%0d", tag, i), 64'(gotq[i]), 64'(expq[i]));
        check_output({tag, "_busy_low"}, 64'(busy_low), 64'(dones_wanted - 1));
        if (want_done_idx >= 0)
            check_output({tag, "_done_cycle"}, 64'(done_idx), 64'(want_done_idx));
        if (check_tail)
            check_output({tag, "_done_after_last"}, 64'(done_idx - last_xfer_idx), 64'(1));
    endtask

    initial begin
        reset        = 1'b1;
        update       = 1'b0;
        ball_x       = '0;
        ball_y       = '0;
        pixel_ready  = 1'b1;
        ready_random = 1'b0;
        held         = 1'b0;
        m_valid      = 1'b0;
        m_x          = 0;
        m_y          = 0;
        idx          = 0;

        do_reset();
        $display("[TB] first draw, no erase");
        run_repaint("first", 115, 155, 1'b0, -1, 0, 0, 101, 1'b1);

        $display("[TB] move by one: erase then draw");
        run_repaint("move", 116, 156, 1'b0, -1, 0, 0, 201, 1'b1);

        $display("[TB] random ready backpressure");
        run_repaint("backpressure", 30, 40, 1'b1, -1, 0, 0, -1, 1'b1);

        $display("[TB] same position, no writes");
        run_repaint("same", 30, 40, 1'b0, -1, 0, 0, 1, 1'b0);

        $display("[TB] update during erase collapses to a later repaint");
        run_repaint("pending", 50, 60, 1'b0, 20, 70, 80, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            run_repaint($sformatf("random%0d", r), int'($urandom_range(0, SCREEN_W - 1)),
                        int'($urandom_range(0, SCREEN_H - 1)), 1'b1, -1, 0, 0, -1, 1'b0);
        end

        $display("[TB] right-edge clipping");
        do_reset();
        run_repaint("clip", 235, 100, 1'b0, -1, 0, 0, 101, 1'b0);

        $display("[TB] bottom-right corner clipping");
        run_repaint("corner", 236, 315, 1'b1, -1, 0, 0, -1, 1'b0);

        $display("[TB] reset in the middle of a draw");
        do_reset();
        ball_x = 8'd10;
        ball_y = 9'd10;
        update = 1'b1;
        step();
        update = 1'b0;
        repeat (5) step();
        check_output("abort_write_before", 64'(pixel_write), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("abort_write", 64'(pixel_write), 64'(0));
        check_output("abort_x", 64'(pixel_x), 64'(0));
        check_output("abort_y", 64'(pixel_y), 64'(0));
        check_output("abort_colour", 64'(pixel_colour), 64'(0));
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_done", 64'(done), 64'(0));
        reset   = 1'b0;
        m_valid = 1'b0;
        held    = 1'b0;
        run_repaint("recover", 20, 20, 1'b0, -1, 0, 0, 101, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
